// File: rtl/io_ccff_loader.sv
// Streams a bitstream into an IO-tile configuration flop chain, bit 0 first, so image bit 0
// settles in the flop nearest the tail. Define IO_CCFF_READBACK_EN to add the re-shift readback check.
module io_ccff_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int BC_W      = $clog2(CHAIN_LEN + 1);
  localparam int WC_W      = $clog2(NWORDS + 1);
  localparam int BUF_CW    = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Handshake: a word moves on a prog_clk edge where cfg_valid && cfg_ready; cfg_data is
  // sampled on that edge only, and cfg_valid may stay high across back-to-back words.
  state_t              state_q, state_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]     words_left_q, words_left_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic [BUF_CW-1:0]   buf_cnt_q, buf_cnt_d;
  logic                shift_load;
  logic                accept;
  logic                unused_tail;

`ifdef IO_CCFF_READBACK_EN
  logic [CHAIN_LEN-1:0] image_q, image_d;
  logic [CHAIN_LEN:0]   image_in;
  logic [CHAIN_LEN:0]   image_rot;
  logic                 err_q, err_d;
`endif

  assign shift_load    = (state_q == S_LOAD) && (buf_cnt_q != '0);
  assign cfg_ready     = (state_q == S_LOAD) && (words_left_q != '0) &&
                         (buf_cnt_q <= BUF_CW'(1));
  assign accept        = cfg_ready && cfg_valid;
  assign ccff_shift_en = shift_load || (state_q == S_VERIFY);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign dbg_state_o   = state_q;
  assign unused_tail   = ccff_tail;

`ifdef IO_CCFF_READBACK_EN
  assign ccff_head = shift_load ? buf_q[0] :
                     (state_q == S_VERIFY) ? image_q[0] : 1'b0;
  assign err       = err_q;
  // Image fills from the top so bit 0 ends at index 0; VERIFY rotates it back through the chain.
  assign image_in  = {ccff_head, image_q};
  assign image_rot = {image_q[0], image_q};
`else
  assign ccff_head = shift_load ? buf_q[0] : 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    words_left_d = words_left_q;
    buf_d        = buf_q;
    buf_cnt_d    = buf_cnt_q;
`ifdef IO_CCFF_READBACK_EN
    image_d      = image_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          bit_cnt_d    = '0;
          words_left_d = WC_W'(NWORDS);
          buf_d        = '0;
          buf_cnt_d    = '0;
`ifdef IO_CCFF_READBACK_EN
          err_d        = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        // A new word may land in the same cycle the last buffered bit shifts out.
        if (accept) begin
          buf_d        = cfg_data;
          buf_cnt_d    = (words_left_q == WC_W'(1)) ? BUF_CW'(LAST_BITS) : BUF_CW'(WORD_W);
          words_left_d = words_left_q - WC_W'(1);
        end else if (shift_load) begin
          buf_d     = buf_q >> 1;
          buf_cnt_d = buf_cnt_q - BUF_CW'(1);
        end
        if (shift_load) begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
`ifdef IO_CCFF_READBACK_EN
          image_d   = image_in[CHAIN_LEN:1];
`endif
          if (bit_cnt_q == BC_W'(CHAIN_LEN - 1)) begin
            bit_cnt_d = '0;
`ifdef IO_CCFF_READBACK_EN
            state_d   = S_VERIFY;
`else
            state_d   = S_DONE;
`endif
          end
        end
      end
`ifdef IO_CCFF_READBACK_EN
      S_VERIFY: begin
        image_d   = image_rot[CHAIN_LEN:1];
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (ccff_tail != image_q[0]) err_d = 1'b1;
        if (bit_cnt_q == BC_W'(CHAIN_LEN - 1)) begin
          bit_cnt_d = '0;
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      words_left_q <= '0;
      buf_q        <= '0;
      buf_cnt_q    <= '0;
`ifdef IO_CCFF_READBACK_EN
      image_q      <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      words_left_q <= words_left_d;
      buf_q        <= buf_d;
      buf_cnt_q    <= buf_cnt_d;
`ifdef IO_CCFF_READBACK_EN
      image_q      <= image_d;
      err_q        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_io_ccff_loader.sv
// Bench for io_ccff_loader: behavioural 8-flop chain, directed loads, and a done-triggered
// scoreboard comparing final chain image, shift count, latency, stalls and err.
module tb_io_ccff_loader;

  localparam int CL = 8;
  localparam int WW = 4;
`ifdef IO_CCFF_READBACK_EN
  localparam int EXP_SHIFTS = 16;
`else
  localparam int EXP_SHIFTS = 8;
`endif

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic          start;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    dbg_state;

  io_ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 prog_clk = ~prog_clk;

  // ---------------- chain model: chain[0] = subtile 0 (head side) ----------------
  logic [CL-1:0] chain = '0;
  logic          stuck3 = 1'b0;
  int            ps_cnt = 0;

  function automatic logic [CL-1:0] shift_model(input logic [CL-1:0] c, input logic h,
                                                input logic stuck);
    logic [CL-1:0] n;
    n = {c[CL-2:0], h};
    if (stuck) n[3] = 1'b0;
    return n;
  endfunction

  assign ccff_tail = chain[CL-1];

  always @(posedge prog_clk) begin
    if (ccff_shift_en) begin
      chain  <= shift_model(chain, ccff_head, stuck3);
      ps_cnt <= ps_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [CL-1:0] chain;
    int            shifts;
    int            lat;
    int            stalls;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [CL-1:0] c, input logic e, input int stalls);
    exp_t x;
    x.chain  = c;
    x.err    = e;
    x.stalls = stalls;
    x.shifts = EXP_SHIFTS;
    x.lat    = EXP_SHIFTS + 1 + stalls;
    exp_q.push_back(x);
  endtask

  // ---------------- monitor ----------------
  int m_shifts = 0;
  int m_lat    = 0;
  int m_stalls = 0;
  int done_cnt = 0;
  bit m_first  = 1'b0;

  always @(negedge prog_clk) begin
    exp_t e;
    if (pReset) begin
      m_shifts = 0; m_lat = 0; m_stalls = 0; m_first = 1'b0;
    end else begin
      if (ccff_shift_en) begin
        m_shifts++;
        m_first = 1'b1;
      end
      if (m_first) m_lat++;
      if (m_first && busy && !ccff_shift_en && !done) m_stalls++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("chain_image", int'(chain), int'(e.chain));
          check("shift_count", m_shifts, e.shifts);
          check("done_latency", m_lat, e.lat);
          check("stall_cycles", m_stalls, e.stalls);
          check("err_at_done", int'(err), int'(e.err));
          check("shift_en_in_done", int'(ccff_shift_en), 0);
        end
        m_shifts = 0; m_lat = 0; m_stalls = 0; m_first = 1'b0;
      end
    end
  end

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic do_start();
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    int n;
    cfg_data  = w;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge prog_clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 0, 1);
    @(posedge prog_clk);
    @(negedge prog_clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge prog_clk);
      n++;
    end
    if (n >= 100) check("done_timeout", 0, 1);
    @(negedge prog_clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cfg_ready"}, int'(cfg_ready), 0);
    check({tag, "_ccff_head"}, int'(ccff_head), 0);
    check({tag, "_shift_en"},  int'(ccff_shift_en), 0);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_done"},      int'(done), 0);
    check({tag, "_err"},       int'(err), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int dcnt;
    pReset    = 1'b1;
    start     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge prog_clk);
    pReset = 1'b0;
    repeat (2) @(negedge prog_clk);
    check("idle_after_reset_busy", int'(busy), 0);

    // Streamed load: 0x5 then 0xA, valid held high.
    push_exp(8'hA5, 1'b0, 0);
    do_start();
    send_word(4'h5);
    send_word(4'hA);
    cfg_valid = 1'b0;
    wait_done();

    // Three idle cycles between words.
    push_exp(8'hA5, 1'b0, 3);
    do_start();
    send_word(4'h5);
    cfg_valid = 1'b0;
    while (!cfg_ready) @(negedge prog_clk);
    repeat (3) @(negedge prog_clk);
    send_word(4'hA);
    cfg_valid = 1'b0;
    wait_done();

    // cfg_valid in IDLE is ignored.
    cfg_data  = 4'h3;
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge prog_clk);
      check("idle_valid_ready", int'(cfg_ready), 0);
      check("idle_valid_shift", int'(ccff_shift_en), 0);
    end
    cfg_valid = 1'b0;

    // start during LOAD ignored; extra valid word after the load is not taken.
    push_exp(8'hA5, 1'b0, 0);
    base = ps_cnt;
    do_start();
    send_word(4'h5);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    send_word(4'hA);
    cfg_data = 4'hC;
    wait_done();
    cfg_valid = 1'b0;
    check("ignored_total_shifts", ps_cnt - base, EXP_SHIFTS);

    // Reset after five shifts, then a full 0xF/0xF load.
    base = ps_cnt;
    do_start();
    send_word(4'h5);
    send_word(4'hA);
    cfg_valid = 1'b0;
    @(negedge prog_clk);
    check("shifts_before_reset", ps_cnt - base, 5);
    dcnt   = done_cnt;
    pReset = 1'b1;
    #1;
    check_outputs_zero("midload_reset");
    repeat (3) @(negedge prog_clk);
    pReset = 1'b0;
    repeat (4) @(negedge prog_clk);
    check("no_done_after_abort", done_cnt, dcnt);
    check("idle_after_abort_busy", int'(busy), 0);
    push_exp(8'hFF, 1'b0, 0);
    do_start();
    send_word(4'hF);
    send_word(4'hF);
    cfg_valid = 1'b0;
    wait_done();

`ifdef IO_CCFF_READBACK_EN
    // Stuck-at-0 on subtile 3 must be caught and held until the next start.
    stuck3 = 1'b1;
    push_exp(8'h05, 1'b1, 0);
    do_start();
    send_word(4'h5);
    send_word(4'hA);
    cfg_valid = 1'b0;
    wait_done();
    for (int i = 0; i < 3; i++) begin
      check("err_sticky", int'(err), 1);
      @(negedge prog_clk);
    end
    stuck3 = 1'b0;
    push_exp(8'hA5, 1'b0, 0);
    do_start();
    check("err_cleared_by_start", int'(err), 0);
    send_word(4'h5);
    send_word(4'hA);
    cfg_valid = 1'b0;
    wait_done();
`endif

    repeat (3) @(negedge prog_clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_ccff_loader.md
IO_CCFF_LOADER -- requirements
Module: io_ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, meaning the number of configuration flops in the IO tile chain (one per IO subtile), range 1..256.
REQ-002 SHALL have parameter WORD_W, default 4, meaning the width of the bitstream input word, range 1..32.
REQ-003 prog_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 pReset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin programming the chain.
REQ-006 cfg_data  input  WORD_W  bitstream word, bit 0 shifted first.
REQ-007 cfg_valid  input  1  cfg_data valid.
REQ-008 cfg_ready  output  1  loader accepts cfg_data this cycle.
REQ-009 ccff_head  output  1  serial data into the chain head.
REQ-010 ccff_shift_en  output  1  chain clock enable; the chain shifts on a prog_clk edge only when this is high.
REQ-011 ccff_tail  input  1  serial data out of the chain tail.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse at end of programming.
REQ-014 err  output  1  sticky readback mismatch flag.

Function
REQ-015 SHALL implement the states IDLE, LOAD, VERIFY and DONE; VERIFY exists only per REQ-030.
REQ-016 IDLE: start=1 -> LOAD; clear bit counter, word buffer and err.
REQ-017 LOAD: a word transfers when cfg_valid && cfg_ready; the loader accepts exactly ceil(CHAIN_LEN/WORD_W) words; unused upper bits of the last word are discarded.
REQ-018 cfg_ready=1 only in LOAD, with words still owed and at most 1 unshifted bit in the buffer, so back-to-back words stream with no bubble.
REQ-019 Each cycle in LOAD with a buffered bit: ccff_head=that bit, ccff_shift_en=1, bit counter +1; with the buffer empty: ccff_shift_en=0 (stall) and the chain holds.
REQ-020 The first bit shifted (image bit 0) SHALL end in the flop nearest ccff_tail (subtile CHAIN_LEN-1), and the last bit in subtile 0.
REQ-021 When the bit counter reaches CHAIN_LEN, LOAD -> VERIFY (macro defined) or DONE (macro undefined); exactly CHAIN_LEN shifts occur in LOAD.
REQ-022 DONE: done=1 for exactly one cycle, ccff_shift_en=0 -> IDLE.
REQ-023 start while busy SHALL be ignored; cfg_valid outside LOAD SHALL be ignored.
REQ-024 ccff_shift_en SHALL never be high in IDLE or DONE.

Reset
REQ-025 Assertion of pReset SHALL immediately force IDLE, and cfg_ready, ccff_head, ccff_shift_en, busy, done and err to 0, and clear the counters and buffer.
REQ-026 Reset mid-LOAD or mid-VERIFY SHALL abandon the operation without a done pulse; the chain contents are then undefined until the next complete load.
REQ-027 After deassertion the block SHALL stay in IDLE until start.

Configuration
REQ-028 Macro IO_CCFF_READBACK_EN SHALL compile the readback check in or out.
REQ-029 With the macro defined: LOAD stores all CHAIN_LEN image bits internally.
REQ-030 With the macro defined, VERIFY SHALL re-shift the stored image for CHAIN_LEN cycles with ccff_shift_en=1 and no stalls, and in shift k compare ccff_tail with image bit k.
REQ-031 Any VERIFY mismatch SHALL set err; err holds until the next accepted start or reset.
REQ-032 After VERIFY the chain SHALL again hold the image; VERIFY -> DONE.
REQ-033 With the macro undefined: no image storage, no VERIFY state, and err tied to 0.

Verification
REQ-034 Bench SHALL use CHAIN_LEN=8, WORD_W=4 and a behavioural 8-flop chain model for all scenarios.
REQ-035 Stream load: start, words 0x5 then 0xA with cfg_valid held high -> 8 consecutive shift cycles; chain subtile7..0 = 1,0,1,0,0,1,0,1; done pulse; err=0.
REQ-036 Stall: insert 3 idle cycles with cfg_valid=0 between the two words -> ccff_shift_en=0 for exactly 3 cycles; same final chain contents as REQ-035; done pulse.
REQ-037 Readback (macro defined): REQ-035 stimulus -> 8 LOAD shifts plus 8 VERIFY shifts, done at the 17th cycle after the first shift, err=0; forcing model bit 3 stuck at 0 -> err=1 and stays 1 until the next start.
REQ-038 Reset mid-LOAD: pReset asserted after 5 shifts -> outputs 0 immediately, no done pulse; a following full load with 0xF, 0xF -> all flops 1.
REQ-039 Ignored inputs: start pulsed during LOAD, and cfg_valid=1 while in IDLE -> no state change, no extra word accepted, shift count stays exactly 8 (or 16 with the macro defined).
